// File: rtl/bnn_stim_harness.sv
// LFSR stimulus generator and MISR response-capture harness for BNN layers.
// Vectors flow through a LATENCY-deep valid pipe and are captured per output channel.
`timescale 1ns/1ps

module bnn_stim_harness #(
  parameter int STIM_W  = 256,
  parameter int NUM_OUT = 64,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  parameter int LATENCY = 2,
  parameter int TAP_A   = 253,
  parameter int TAP_B   = 250,
  parameter int TAP_C   = 245,
  parameter logic [STIM_W-1:0] SEED = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ap_ce,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_vectors,
  output logic [STIM_W-1:0]        stim,
  input  logic [NUM_OUT*OUT_W-1:0] dut_out,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     sel_mode,
  output logic [OUT_W-1:0]         data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] NUM_OUT_L = (ADDR_W+1)'(NUM_OUT);

  state_t             state;
  logic [CNT_W-1:0]   vec_cnt;
  logic [CNT_W-1:0]   vec_total;
  logic [LATENCY-1:0] vpipe;
  logic [LATENCY-1:0] vpipe_next;
  logic [OUT_W-1:0]   cap [NUM_OUT];
  logic [OUT_W-1:0]   sig [NUM_OUT];
  logic               fb;
  logic               issue;
  logic               capture;
  logic               accept;

  always_comb begin
    fb      = stim[STIM_W-1] ^ stim[TAP_A] ^ stim[TAP_B] ^ stim[TAP_C];
    issue   = ap_ce && (state == RUN);
    capture = ap_ce && vpipe[LATENCY-1];
    accept  = start && ((state == IDLE) || (state == DONE));
    vpipe_next    = '0;
    vpipe_next[0] = issue;
    for (int i = 1; i < LATENCY; i++) begin
      vpipe_next[i] = vpipe[i-1];
    end
  end

  // Start is honoured even with ap_ce low; everything else waits for ap_ce.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stim      <= SEED;
      vec_cnt   <= '0;
      vec_total <= '0;
      vpipe     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      vec_total <= num_vectors;
      stim      <= SEED;
      vec_cnt   <= '0;
      vpipe     <= '0;
      if (num_vectors == '0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else if (ap_ce) begin
      vpipe <= vpipe_next;
      case (state)
        RUN: begin
          stim    <= {stim[STIM_W-2:0], fb};
          vec_cnt <= vec_cnt + 1'b1;
          if (vec_cnt + 1'b1 == vec_total) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vpipe_next == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Per-channel last value and rotate-XOR signature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        cap[i] <= '0;
        sig[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        cap[i] <= '0;
        sig[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        cap[i] <= dut_out[i*OUT_W +: OUT_W];
        sig[i] <= {sig[i][OUT_W-2:0], sig[i][OUT_W-1]} ^ dut_out[i*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if ({1'b0, addr} < NUM_OUT_L) begin
      data <= sel_mode ? sig[addr] : cap[addr];
    end else begin
      data <= '0;
    end
  end

endmodule

// File: tb/tb_bnn_stim_harness.sv
// Directed bench for bnn_stim_harness on an 8-bit LFSR, 6-channel configuration.
`timescale 1ns/1ps

module tb_bnn_stim_harness;

  localparam int NCH = 6;
  localparam logic [7:0] SEED_V = 8'h01;

  logic              clk = 1'b0;
  logic              rst;
  logic              ap_ce;
  logic              start;
  logic [15:0]       num_vectors;
  logic [7:0]        stim;
  logic [NCH*16-1:0] dut_out;
  logic [2:0]        addr;
  logic              sel_mode;
  logic [15:0]       data;
  logic              busy;
  logic              done;

  logic              dut_mode;
  logic [NCH*16-1:0] f1 = '0;
  logic [NCH*16-1:0] f2 = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    int          stall_at;
    int          stall_len;
    int          exp_busy;
    logic [15:0] exp_sig;
    logic [15:0] exp_cap;
  } vec_t;

  vec_t vectors [7];

  bnn_stim_harness #(
    .STIM_W(8), .NUM_OUT(NCH), .OUT_W(16), .LATENCY(2),
    .TAP_A(5), .TAP_B(4), .TAP_C(3), .SEED(SEED_V), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ap_ce(ap_ce), .start(start),
    .num_vectors(num_vectors), .stim(stim), .dut_out(dut_out),
    .addr(addr), .sel_mode(sel_mode), .data(data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [15:0] dut_f(input logic [7:0] v, input int ch);
    logic [7:0] c;
    c = 8'(ch * 37 + 1);
    return {v ^ c, v + 8'(ch)};
  endfunction

  function automatic logic [15:0] model_sig(input int n, input int ch);
    logic [7:0]  s;
    logic [15:0] g;
    s = SEED_V;
    g = '0;
    for (int k = 0; k < n; k++) begin
      g = {g[14:0], g[15]} ^ dut_f(s, ch);
      s = lfsr_step(s);
    end
    return g;
  endfunction

  function automatic logic [15:0] model_cap(input int n, input int ch);
    logic [7:0] s;
    s = SEED_V;
    for (int k = 0; k < n - 1; k++) s = lfsr_step(s);
    return (n == 0) ? 16'h0000 : dut_f(s, ch);
  endfunction

  // Two-stage DUT stand-in, enabled by ap_ce like the real layer.
  always @(posedge clk) begin
    if (ap_ce) begin
      for (int ch = 0; ch < NCH; ch++) f1[ch*16 +: 16] <= dut_f(stim, ch);
      f2 <= f1;
    end
  end

  assign dut_out = dut_mode ? f2 : {NCH{16'h0001}};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic read_out(input logic [2:0] a, input logic s, output logic [15:0] v);
    addr     = a;
    sel_mode = s;
    @(posedge clk); #1;
    v = data;
  endtask

  task automatic apply_stimulus(input int n, input int stall_at, input int stall_len,
                                input int start_at, output int busy_cycles);
    logic [7:0] hold;
    hold        = '0;
    busy_cycles = 0;
    num_vectors = 16'(n);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (done) break;
      if (busy) busy_cycles++;
      if (k == stall_at) hold = stim;
      if (stall_len > 0 && k == stall_at + stall_len) check_output("stall_stim", 32'(stim), 32'(hold));
      ap_ce = !(k >= stall_at && k < stall_at + stall_len);
      start = (k == start_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    ap_ce = 1'b1;
    check_output("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  s;
    int          bc;

    rst = 1'b0; ap_ce = 1'b1; start = 1'b0; num_vectors = '0;
    addr = '0; sel_mode = 1'b0; dut_mode = 1'b0;

    vectors[0] = '{3, -1, 0, 5, 16'h0007, 16'h0001};
    vectors[1] = '{3, 1, 4, 9, 16'h0007, 16'h0001};
    vectors[2] = '{1, -1, 0, 3, 16'h0001, 16'h0001};
    vectors[3] = '{0, -1, 0, 0, 16'h0000, 16'h0000};
    vectors[4] = '{17, -1, 0, 19, 16'hFFFE, 16'h0001};
    vectors[5] = '{5, 2, 2, 9, 16'h001F, 16'h0001};
    vectors[6] = '{2, 2, 3, 7, 16'h0003, 16'h0001};

    // Reset state, and nothing moves without a start.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_stim", 32'(stim), 32'(SEED_V));
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_data", 32'(data), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("idle_stim", 32'(stim), 32'(SEED_V));
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_done", 32'(done), 32'd0);

    // Stimulus sequence of a 3-vector run, then frozen after the run.
    num_vectors = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = SEED_V;
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("stim_seq%0d", k), 32'(stim), 32'(s));
      s = lfsr_step(s);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
    end
    check_output("seq_done", 32'(done), 32'd1);
    check_output("stim_frozen", 32'(stim), 32'(s));
    repeat (3) @(posedge clk);
    #1;
    check_output("stim_frozen_done", 32'(stim), 32'(s));

    // Constant-response table: busy length, signature and last capture.
    for (int r = 0; r < 7; r++) begin
      apply_stimulus(vectors[r].n, vectors[r].stall_at, vectors[r].stall_len, -1, bc);
      check_output($sformatf("row%0d_busy", r), 32'(bc), 32'(vectors[r].exp_busy));
      read_out(3'd5, 1'b1, v);
      check_output($sformatf("row%0d_sig5", r), 32'(v), 32'(vectors[r].exp_sig));
      read_out(3'd5, 1'b0, v);
      check_output($sformatf("row%0d_cap5", r), 32'(v), 32'(vectors[r].exp_cap));
      read_out(3'd0, 1'b1, v);
      check_output($sformatf("row%0d_sig0", r), 32'(v), 32'(vectors[r].exp_sig));
    end

    // Readout keeps working with ap_ce low; unused addresses read zero.
    apply_stimulus(3, -1, 0, -1, bc);
    ap_ce = 1'b0;
    read_out(3'd5, 1'b0, v);
    check_output("noce_cap5", 32'(v), 32'h0001);
    read_out(3'd5, 1'b1, v);
    check_output("noce_sig5", 32'(v), 32'h0007);
    read_out(3'd6, 1'b1, v);
    check_output("addr6_zero", 32'(v), 32'd0);
    read_out(3'd7, 1'b0, v);
    check_output("addr7_zero", 32'(v), 32'd0);
    ap_ce = 1'b1;

    // Data-dependent reference run with a start pulse in the middle of RUN.
    dut_mode = 1'b1;
    apply_stimulus(10, -1, 0, 3, bc);
    check_output("ref_busy", 32'(bc), 32'd12);
    for (int ch = 0; ch < NCH; ch++) begin
      read_out(3'(ch), 1'b1, v);
      check_output($sformatf("ref_sig%0d", ch), 32'(v), 32'(model_sig(10, ch)));
    end
    read_out(3'd2, 1'b0, v);
    check_output("ref_cap2", 32'(v), 32'(model_cap(10, 2)));

    // Reset pulse partway through a run, then an uninterrupted rerun.
    num_vectors = 16'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_data", 32'(data), 32'd0);
    check_output("midrst_stim", 32'(stim), 32'(SEED_V));
    @(negedge clk) rst = 1'b1;
    read_out(3'd5, 1'b1, v);
    check_output("midrst_sig5", 32'(v), 32'd0);
    apply_stimulus(10, -1, 0, -1, bc);
    check_output("rerun_busy", 32'(bc), 32'd12);
    for (int ch = 0; ch < NCH; ch++) begin
      read_out(3'(ch), 1'b1, v);
      check_output($sformatf("rerun_sig%0d", ch), 32'(v), 32'(model_sig(10, ch)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_stim_harness.md
Name: bnn_stim_harness

Overview:
Parametrised random-stimulus and response-capture harness for koios BNN layers. Drives a DUT input bus from an internal LFSR for a programmed number of vectors. Captures every DUT output channel after a fixed pipeline latency and folds it into a per-channel signature (MISR). Exposes any captured value or signature through an addressed, registered readout port.

Parameters:
STIM_W, 256, stimulus/LFSR width (>=8)
NUM_OUT, 64, number of DUT output channels
OUT_W, 16, width of each DUT output channel (>=2)
ADDR_W, $clog2(NUM_OUT), readout address width (derived)
LATENCY, 2, DUT pipeline depth in ap_ce cycles (>=1)
TAP_A/TAP_B/TAP_C, 253/250/245, extra LFSR feedback taps (bit STIM_W-1 always tapped)
SEED, 1, LFSR load value; must be nonzero
CNT_W, 16, vector-counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ap_ce  in  1  global clock enable; also drives DUT enable externally
start  in  1  one-cycle launch pulse
num_vectors  in  CNT_W  vectors per run, sampled on accepted start
stim  out  STIM_W  LFSR vector to DUT (registered)
dut_out  in  NUM_OUT*OUT_W  DUT outputs; channel i = bits [i*OUT_W +: OUT_W]
addr  in  ADDR_W  readout channel select
sel_mode  in  1  0 = last captured value, 1 = signature
data  out  OUT_W  registered readout
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, stim=SEED, vec_cnt=0, valid pipe=0, all cap[i]=0, all sig[i]=0, data=0, busy=0, done=0.
- LFSR step: stim <= {stim[STIM_W-2:0], fb}, where fb = stim[STIM_W-1]^stim[TAP_A]^stim[TAP_B]^stim[TAP_C].
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with start=1: latch num_vectors, stim<=SEED, vec_cnt<=0, clear cap/sig/valid pipe.
  - Next state RUN, or DONE if num_vectors==0 (busy never rises).
  - start is accepted regardless of ap_ce.
- RUN, ap_ce=1: the vector currently on stim counts as issued.
  - issue bit=1 enters the valid pipe; LFSR steps; vec_cnt++.
  - When vec_cnt+1 == latched count, go to DRAIN.
  - First issued vector = SEED.
- DRAIN: no issue and no LFSR step; go to DONE on the cycle the valid pipe becomes all-zero after its last capture.
- ap_ce=0 in any state: LFSR, vec_cnt, valid pipe, captures and FSM progress all freeze. data readout still updates.
- start in RUN/DRAIN: ignored.
- Valid pipe: LATENCY-bit shift register, vpipe <= {vpipe[LATENCY-2:0], issue}. A vector issued in ce-cycle t has its DUT result on dut_out in ce-cycle t+LATENCY, when vpipe[LATENCY-1]=1.
- Capture on (ap_ce && vpipe[LATENCY-1]), for every channel i:
  - cap[i] <= dut_out_i
  - sig[i] <= {sig[i][OUT_W-2:0], sig[i][OUT_W-1]} ^ dut_out_i (rotate-left-by-1 then XOR)
- Readout: data <= sel_mode ? sig[addr] : cap[addr], one-cycle latency, every cycle. addr >= NUM_OUT reads 0.
- done holds until the next accepted start or reset. cap/sig hold their values in DONE.
- Total busy duration with ap_ce=1: N + LATENCY cycles for N>0 vectors.
- Reset mid-run: immediate return to reset values. A subsequent run reproduces identical results, because the LFSR is reloaded with SEED.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> stim=SEED, data=0, busy=0, done=0. No change without start.
2. STIM_W=8, taps 7/5/4/3, SEED=8'h01, num_vectors=3, start -> stim sequence 8'h01, 8'h02, 8'h04, then frozen in DRAIN/DONE.
3. LATENCY=2, num_vectors=3, ap_ce=1, bench drives every channel 16'h0001 -> busy high 5 cycles, then done=1. sig becomes 0x0001, 0x0003, 0x0007. addr=5, sel_mode=1 -> data=16'h0007 one cycle later. sel_mode=0 -> 16'h0001.
4. Same run as 3 with ap_ce=0 for 4 cycles mid-RUN -> stim and vec_cnt frozen during the stall, busy lasts 9 cycles, final sig still 16'h0007.
5. num_vectors=0, start -> done=1 the next cycle, busy stays 0, sig remains 0. Pulse start during RUN of a 10-vector run -> ignored, vector count still 10.
6. Pulse rst low for one cycle at vector 4 of a 10-vector run -> busy=0 and sig=0 immediately. Rerun with the same DUT model -> signatures identical to an uninterrupted reference run.
